// File: rtl/skewed_data_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetcher_pkg
// Brief    : Shared state encoding and width helpers for skewed_data_fetcher.
// Revision : 1.0
// ============================================================================
package fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } fetch_state_t;

    // Buffer address width for an NxN matrix, never below one bit
    function automatic int calc_addr_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Row pointer / drain counter width, never below one bit
    function automatic int calc_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skewed_data_fetcher_skew_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_line
// Brief    : DEPTH-stage delay line with stall and valid; DEPTH 0 is a wire.
// Revision : 1.0
// ============================================================================
module skew_line #(
    parameter int DEPTH     = 1,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic                 o_valid,
    output logic [DATA_SIZE-1:0] o_data
);

    if (DEPTH == 0) begin : g_passthru
        logic w_unused_ctrl;
        assign w_unused_ctrl = clk ^ reset ^ enable;
        assign o_valid       = i_valid;
        assign o_data        = i_data;
    end else begin : g_pipe
        logic [DATA_SIZE-1:0] r_data [DEPTH];
        logic [DEPTH-1:0]     r_valid;

        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int s = 0; s < DEPTH; s++) begin
                    r_data[s] <= '0;
                end
                r_valid <= '0;
            end else if (enable) begin
                r_data[0]  <= i_data;
                r_valid[0] <= i_valid;
                for (int s = 1; s < DEPTH; s++) begin
                    r_data[s]  <= r_data[s-1];
                    r_valid[s] <= r_valid[s-1];
                end
            end
        end

        assign o_data  = r_data[DEPTH-1];
        assign o_valid = r_valid[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/skewed_data_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : skewed_data_fetcher
// Brief    : Streams an NxN operand buffer row by row into a systolic edge,
//            lane i delayed i cycles to form the diagonal wavefront.
// Revision : 1.0
// ============================================================================
module skewed_data_fetcher
    import fetcher_pkg::*;
#(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_SIZE   = 32,
    parameter int INTERVAL_W  = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic                                       load_en,
    input  logic [calc_addr_w(MATRIX_SIZE)-1:0]        load_addr,
    input  logic [DATA_SIZE-1:0]                       load_data,
    input  logic                                       start,
    input  logic [INTERVAL_W-1:0]                      interval,
    output logic                                       busy,
    output logic                                       done,
    output logic [DATA_SIZE-1:0]                       data_out [MATRIX_SIZE],
    output logic [MATRIX_SIZE-1:0]                     valid_out
);

    localparam int ADDR_W      = calc_addr_w(MATRIX_SIZE);
    localparam int PTR_W       = calc_ptr_w(MATRIX_SIZE);
    localparam int c_MEM_DEPTH = MATRIX_SIZE * MATRIX_SIZE;

    localparam logic [ADDR_W:0]  c_MEM_DEPTH_X = (ADDR_W + 1)'(c_MEM_DEPTH);
    localparam logic [PTR_W-1:0] c_LAST        = PTR_W'(MATRIX_SIZE - 1);

    fetch_state_t           r_state;
    logic [INTERVAL_W-1:0]  r_interval_q;
    logic [INTERVAL_W-1:0]  r_interval_cnt;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_drain_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [DATA_SIZE-1:0]   r_mem [c_MEM_DEPTH];
    logic [DATA_SIZE-1:0]   r_issue_data [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0] r_issue_valid;

    logic                   w_load_ok;
    logic                   w_issue;
    logic [ADDR_W-1:0]      w_row_base;

    assign w_load_ok  = load_en && ({1'b0, load_addr} < c_MEM_DEPTH_X);
    assign w_issue    = (r_state == STREAM) && (r_interval_cnt == r_interval_q);
    assign w_row_base = ADDR_W'(r_ptr) * ADDR_W'(MATRIX_SIZE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_interval_q   <= '0;
            r_interval_cnt <= '0;
            r_ptr          <= '0;
            r_drain_cnt    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_issue_valid  <= '0;
            for (int a = 0; a < c_MEM_DEPTH; a++) begin
                r_mem[a] <= '0;
            end
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                r_issue_data[i] <= '0;
            end
        end else if (enable) begin
            // Non-issue cycles inject zeros so the array sees a clean bubble
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                r_issue_data[i] <= w_issue ? r_mem[w_row_base + ADDR_W'(i)] : '0;
            end
            r_issue_valid <= {MATRIX_SIZE{w_issue}};

            case (r_state)
                IDLE: begin
                    if (w_load_ok) begin
                        r_mem[load_addr] <= load_data;
                    end
                    if (start) begin
                        r_state        <= STREAM;
                        r_interval_q   <= interval;
                        r_interval_cnt <= '0;
                        r_ptr          <= '0;
                        r_busy         <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_issue) begin
                        r_interval_cnt <= '0;
                        if (r_ptr == c_LAST) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= '0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end else begin
                        r_interval_cnt <= r_interval_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Held until the deepest lane has presented its last row
                    if (r_drain_cnt == c_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
        skew_line #(
            .DEPTH     (gi),
            .DATA_SIZE (DATA_SIZE)
        ) u_skew (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .i_valid (r_issue_valid[gi]),
            .i_data  (r_issue_data[gi]),
            .o_valid (valid_out[gi]),
            .o_data  (data_out[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_skewed_data_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_skewed_data_fetcher
// Brief    : Scoreboard bench; expected lane events derive from stream timing.
// Revision : 1.0
// ============================================================================
module tb_skewed_data_fetcher;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int AW = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          enable    = 1'b1;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          start     = 1'b0;
    logic [IW-1:0] interval  = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] data_out [N];
    logic [N-1:0]  valid_out;

    skewed_data_fetcher #(
        .MATRIX_SIZE (N),
        .DATA_SIZE   (DW),
        .INTERVAL_W  (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .interval  (interval),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            lane;
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] model [N*N];
    int            ecyc     = 0;
    logic          adv      = 1'b0;
    logic          rst_edge = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          active   = 1'b0;
    int            stream_e = 0;
    int            done_e   = 0;
    logic [DW-1:0] snap_data [N];
    logic [N-1:0]  snap_valid;
    logic          snap_busy;
    logic          snap_done;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (ecyc %0d)", tag, act, exp, ecyc);
        end
    endtask

    // ecyc counts only edges that advance the design, so stalls need no special math
    always @(posedge clk) begin
        adv      <= enable;
        rst_edge <= !reset;
        if (enable) ecyc <= ecyc + 1;
    end

    always @(negedge clk) begin : mon
        int   idx;
        logic eb;
        logic ed;
        if (rst_edge) begin
            for (int i = 0; i < N; i++) check_eq("rst_data", 64'(data_out[i]), 64'(0));
            check_eq("rst_valid", 64'(valid_out), 64'(0));
            check_eq("rst_busy", 64'(busy), 64'(0));
            check_eq("rst_done", 64'(done), 64'(0));
        end else if (adv) begin
            for (int i = 0; i < N; i++) begin
                if (valid_out[i]) begin
                    idx = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (idx < 0 && sb[j].lane == i) idx = j;
                    end
                    if (idx < 0) begin
                        check_eq("unexp_valid", 64'(valid_out[i]), 64'(0));
                    end else begin
                        check_eq("lane_cycle", 64'(ecyc), 64'(sb[idx].cyc));
                        check_eq("lane_data", 64'(data_out[i]), 64'(sb[idx].data));
                        sb.delete(idx);
                    end
                end else begin
                    check_eq("zero_inject", 64'(data_out[i]), 64'(0));
                end
            end
            eb = active && (ecyc >= stream_e) && (ecyc < done_e);
            ed = active && (ecyc == done_e);
            check_eq("busy", 64'(busy), 64'(eb));
            check_eq("done", 64'(done), 64'(ed));
            if (ed) active = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) check_eq("freeze_data", 64'(data_out[i]), 64'(snap_data[i]));
            check_eq("freeze_valid", 64'(valid_out), 64'(snap_valid));
            check_eq("freeze_busy", 64'(busy), 64'(snap_busy));
            check_eq("freeze_done", 64'(done), 64'(snap_done));
        end
        for (int i = 0; i < N; i++) snap_data[i] = data_out[i];
        snap_valid = valid_out;
        snap_busy  = busy;
        snap_done  = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        model[a]  = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Start is sampled at the next edge; row k lane i lands 1+iv+k*P+i edges later
    task automatic launch(input int iv);
        int   e;
        int   p;
        exp_t x;
        e = ecyc + 1;
        p = iv + 1;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                x.lane = i;
                x.cyc  = e + 1 + iv + k * p + i;
                x.data = model[k * N + i];
                sb.push_back(x);
            end
        end
        stream_e = e;
        done_e   = e + 2 + iv + (N - 1) * p + (N - 1);
        active   = 1'b1;
        interval = IW'(iv);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (active && n < budget) begin
            tick();
            n++;
        end
        check_eq("stream_timeout", 64'(active), 64'(0));
        check_eq("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin : drive
        int n;
        for (int a = 0; a < N * N; a++) model[a] = '0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Distinct values, interval 3
        for (int a = 0; a < N * N; a++) load(a, DW'(100 + a));
        launch(3);
        wait_idle(200);

        // Back-to-back rows, buffer holds its own address
        for (int a = 0; a < N * N; a++) load(a, DW'(a));
        launch(0);
        wait_idle(200);

        // A load while frozen in IDLE must not land; then stall mid-stream
        enable    = 1'b0;
        load_en   = 1'b1;
        load_addr = AW'(1);
        load_data = 32'hdead_beef;
        tick();
        load_en   = 1'b0;
        enable    = 1'b1;
        launch(2);
        repeat (4) tick();
        enable = 1'b0;
        start  = 1'b1;
        repeat (3) tick();
        start  = 1'b0;
        enable = 1'b1;
        wait_idle(200);

        // Reset mid-stream: no done, buffer cleared, then a clean rerun
        launch(3);
        repeat (6) tick();
        reset = 1'b0;
        tick();
        sb.delete();
        active = 1'b0;
        reset  = 1'b1;
        repeat (20) tick();
        for (int a = 0; a < N * N; a++) model[a] = '0;
        launch(1);
        wait_idle(200);
        for (int a = 0; a < N * N; a++) load(a, DW'(200 + a));
        launch(3);
        wait_idle(200);

        // Load and start while busy, and start in the DONE cycle, are dropped
        launch(1);
        repeat (3) tick();
        load_en   = 1'b1;
        load_addr = AW'(0);
        load_data = 32'd77;
        start     = 1'b1;
        tick();
        load_en   = 1'b0;
        start     = 1'b0;
        n = 0;
        while (ecyc != done_e && n < 200) begin
            tick();
            n++;
        end
        check_eq("done_wait", 64'(ecyc), 64'(done_e));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check_eq("no_restart_sb", 64'(sb.size()), 64'(0));
        launch(2);
        wait_idle(200);

        // Same-cycle load and start: stream sees the new word
        load_en   = 1'b1;
        load_addr = AW'(0);
        load_data = 32'd9;
        model[0]  = 32'd9;
        launch(0);
        load_en   = 1'b0;
        wait_idle(200);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skewed_data_fetcher.md
Name: skewed_data_fetcher

Overview:
- Parametrised successor to the fixed 2x2 fetcher.
- Holds an NxN operand matrix in a loadable buffer and streams it row by row into the systolic array edge, one row every programmable interval.
- Lane i is delayed i cycles so operands enter the array on the diagonal wavefront.
- Adds start/busy/done control, freeze-on-enable, and per-lane valid.

Parameters:
- MATRIX_SIZE, 4: N; number of lanes and number of rows streamed.
- DATA_SIZE, 32: operand width.
- INTERVAL_W, 4: width of the interval input.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  high = advance; low = freeze all state (shared with array).
- load_en  input  1  buffer write strobe.
- load_addr  input  $clog2(N*N)  row-major address, row*N+lane.
- load_data  input  DATA_SIZE  write data.
- start  input  1  launch a stream; sampled in IDLE only.
- interval  input  INTERVAL_W  extra idle cycles between rows; period P = interval+1.
- busy  output  1  high in STREAM or DRAIN.
- done  output  1  one-cycle pulse at stream end.
- data_out  output  DATA_SIZE x N  unpacked per-lane operand.
- valid_out  output  N  per-lane valid.

Behaviour:
- Reset (reset==0 at an edge) sets:
  - FSM to IDLE.
  - All counters to 0.
  - All buffer entries to 0.
  - data_out to 0, valid_out to 0, busy to 0, done to 0.
- Reset has priority over enable and applies mid-stream. No done pulse is produced for an aborted stream.
- enable==0: FSM, counters, pointer, skew pipeline and all outputs hold; start and load_en are ignored. done, if high, also holds.
- Loads:
  - Written in IDLE only. load_en in any other state is ignored.
  - Addresses >= N*N are ignored.
- start:
  - Ignored unless in IDLE with enable high.
  - On acceptance: latch interval into interval_q, clear pointer and interval counter, go to STREAM.
  - load_en and start in the same IDLE cycle: the write lands and the stream sees the new value.
- STREAM:
  - The interval counter runs 0..interval_q, then wraps.
  - When the counter equals interval_q, issue row r=pointer: lane i is fed dmem[r*N+i] with valid=1, then pointer increments.
  - In all other cycles, lanes are fed 0 with valid=0 (zero injection).
  - After issuing row N-1, go to DRAIN.
- DRAIN:
  - Count N-1 cycles while the skew pipeline empties.
  - Then go to DONE: done=1 for one cycle, busy=0, then IDLE.
- Skew:
  - Lane 0 is registered once.
  - Lane i passes through i further registers, which also carry valid.
- Timing (start sampled in cycle T, enable held high):
  - Row k, lane i is valid in cycle T+2+interval_q+k*P+i.
  - done is high in cycle T+3+interval_q+(N-1)*P+(N-1).
  - Stalls shift every later event by the number of enable-low cycles.
- interval==0 gives back-to-back rows (P=1). No illegal interval values exist.
- Only one stream is in flight at a time. A start during busy or DONE is dropped, not queued.

Decomposition:
- Package fetcher_pkg:
  - fetch_state_t enum: IDLE, STREAM, DRAIN, DONE.
  - localparam helpers: ADDR_W = $clog2(N*N), PTR_W.
- Sub-module skew_line:
  - Parametrised DEPTH and DATA_SIZE delay line with enable, synchronous active-low reset, and a valid bit.
  - Instantiated once per lane with DEPTH = lane index; DEPTH 0 is a wire.

Test Plan:
- N=2, load 1,2,3,4, interval=3, start at cycle 0 -> lane0 = 1 @5 and 3 @9; lane1 = 2 @6 and 4 @10; done @11; zeros with valid=0 at all other cycles.
- N=4, interval=0, buffer = addr value, start @0 -> lane i carries row k value 4k+i at cycle 2+k+i; done @9; busy high cycles 1-8.
- N=2, interval=3, enable low for cycles 6-8 -> outputs frozen at cycle-5 values during the stall; lane1 = 2 @9, row1 lane0 @12, done @14.
- Reset low at cycle 7 mid-stream -> from cycle 8: outputs 0, busy 0, no done; buffer reads 0; a fresh load plus start then reproduces test 1 timing.
- start and load_en asserted while busy -> no second stream, buffer unchanged; the next IDLE run streams the original data.
- load_en (addr 0, value 9) and start in the same IDLE cycle -> first lane0 output is 9.
